fetch_stage: RTL

//  Instruction-fetch stage of the 64-bit LEGv8 pipeline: holds the PC, fetches over a req/ack imem port,
//  and drives the IF/ID register whose instr_o feeds the decode/control unit. Applies resolved branches
//  (B, BL, CBZ, B.LT, BR) from decode, flushing the wrong-path instruction. Honours a hazard-unit stall.

---
 rtl/fetch_stage.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : LEGv8 instruction-fetch stage: PC, req/ack imem port, IF/ID
//            register, branch redirect with wrong-path flush, stall hold.
// Options  : FETCH_ALIGN_CHECK_EN enables the sticky misaligned-target flag.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter int              AW        = 64,
    parameter logic [AW-1:0]   RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'hD503201F
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          stall_i,
    input  logic          br_taken_i,
    input  logic          uncond_br_i,
    input  logic          br_reg_i,
    input  logic [AW-1:0] br_pc_i,
    input  logic [31:0]   br_instr_i,
    input  logic [AW-1:0] br_reg_val_i,
    output logic          imem_req_o,
    output logic [AW-1:0] imem_addr_o,
    input  logic          imem_ack_i,
    input  logic [31:0]   imem_rdata_i,
    output logic [31:0]   instr_o,
    output logic [AW-1:0] pc_o,
    output logic          valid_o,
    output logic          misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    localparam logic [AW-1:0] C_PC_INC     = AW'(4);
    localparam logic [AW-1:0] C_ALIGN_MASK = ~AW'(3);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [AW-1:0] ifpc_q, ifpc_d;
    logic          valid_q, valid_d;
    logic [31:0]   hold_instr_q, hold_instr_d;
    logic [AW-1:0] hold_pc_q, hold_pc_d;
    logic [AW-1:0] disc_addr_q, disc_addr_d;

    logic          redirect;
    logic [AW-1:0] br_offset;
    logic [AW-1:0] target_raw;
    logic [AW-1:0] target_pc;
    logic          unused_instr_bits;

    assign unused_instr_bits = ^{br_instr_i[31:26], br_instr_i[4:0]};

    assign redirect = br_reg_i | br_taken_i;

    always_comb begin
        if (uncond_br_i) begin
            br_offset = {{(AW-28){br_instr_i[25]}}, br_instr_i[25:0], 2'b00};
        end else begin
            br_offset = {{(AW-21){br_instr_i[23]}}, br_instr_i[23:5], 2'b00};
        end
    end

    assign target_raw = br_reg_i ? br_reg_val_i : (br_pc_i + br_offset);
    assign target_pc  = target_raw & C_ALIGN_MASK;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            ifpc_q       <= '0;
            valid_q      <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            disc_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            ifpc_q       <= ifpc_d;
            valid_q      <= valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            disc_addr_q  <= disc_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        ifpc_d       = ifpc_q;
        valid_d      = valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        disc_addr_d  = disc_addr_q;

        if (redirect) begin
            pc_d    = target_pc;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            case (state_q)
                S_FETCH: begin
                    // An unacked request is still in flight; its data must be swallowed.
                    if (!imem_ack_i) begin
                        state_d     = S_DISCARD;
                        disc_addr_d = pc_q;
                    end
                end
                S_DISCARD: begin
                    if (imem_ack_i) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_IDLE: state_d = S_FETCH;
                S_FETCH: begin
                    if (imem_ack_i) begin
                        pc_d = pc_q + C_PC_INC;
                        if (stall_i) begin
                            hold_instr_d = imem_rdata_i;
                            hold_pc_d    = pc_q;
                            state_d      = S_HOLD;
                        end else begin
                            instr_d = imem_rdata_i;
                            ifpc_d  = pc_q;
                            valid_d = 1'b1;
                        end
                    end else if (!stall_i) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        instr_d = hold_instr_q;
                        ifpc_d  = hold_pc_q;
                        valid_d = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (imem_ack_i) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_q <= 1'b0;
        end else if (redirect && (target_raw[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_o = misalign_q;
`else
    assign misalign_o = 1'b0;
`endif

    assign imem_req_o  = (state_q == S_FETCH) || (state_q == S_DISCARD);
    assign imem_addr_o = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
    assign instr_o     = instr_q;
    assign pc_o        = ifpc_q;
    assign valid_o     = valid_q;

endmodule
`default_nettype wire
